// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module  : booth_pkg
// Brief   : Shared types and helpers for the radix-4 Booth multiplier.
// Revision: 1.0 - initial release
// ============================================================================
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Encoding kept identical to the legacy ALUop values
  typedef enum logic [2:0] {
    ZERO = 3'b000,
    ADD1 = 3'b010,
    ADD2 = 3'b011,
    SUB1 = 3'b101,
    SUB2 = 3'b110
  } digit_op_e;

  function automatic int calc_iter(input int width);
    return width / 2 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r4_seq_mult_if.sv
`default_nettype none
// ============================================================================
// Module  : booth_r4_seq_mult_if
// Brief   : Start/ready/done handshake and operand/result bus of the multiplier.
// Revision: 1.0 - initial release
// ============================================================================
interface booth_r4_seq_mult_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, is_signed, a, b,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, is_signed, a, b,
    output ready, busy, done, product
  );
endinterface
`default_nettype wire

// File: rtl/booth_r4_recoder.sv
`default_nettype none
// ============================================================================
// Module  : booth_r4_recoder
// Brief   : Radix-4 Booth digit recoder, multiplier triplet to digit operation.
// Revision: 1.0 - initial release
// ============================================================================
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] i_triplet,
  output digit_op_e  o_op
);

  always_comb begin
    o_op = ZERO;
    case (i_triplet)
      3'b001, 3'b010: o_op = ADD1;
      3'b011:         o_op = ADD2;
      3'b100:         o_op = SUB2;
      3'b101, 3'b110: o_op = SUB1;
      default:        o_op = ZERO;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/booth_r4_seq_mult.sv
`default_nettype none
// ============================================================================
// Module  : booth_r4_seq_mult
// Brief   : Sequential radix-4 Booth multiplier, signed/unsigned, one digit/cycle.
// Revision: 1.0 - initial release
// ============================================================================
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  booth_r4_seq_mult_if.slave bus
);

  localparam int ITER = calc_iter(WIDTH);
  localparam int AW   = 2 * WIDTH + 4;
  localparam int MRW  = 2 * ITER + 1;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] C_LAST = CW'(ITER - 1);

  state_e             r_state;
  state_e             w_state_next;
  logic [AW-1:0]      r_acc;
  logic [AW-1:0]      r_mc;
  logic [AW-1:0]      w_pp;
  logic [AW-1:0]      w_acc_next;
  logic [MRW-1:0]     r_mr;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_product;
  digit_op_e          w_op;
  logic               w_ready;
  logic               w_busy;
  logic               w_done;
  logic               w_accept;
  logic               w_last;
  logic               w_a_sx;
  logic               w_b_sx;

  assign w_a_sx   = bus.is_signed & bus.a[WIDTH-1];
  assign w_b_sx   = bus.is_signed & bus.b[WIDTH-1];
  assign w_last   = (r_count == C_LAST);
  assign w_accept = w_ready & bus.start;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.start) w_state_next = RUN;
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        w_ready      = 1'b1;
        w_done       = 1'b1;
        w_state_next = bus.start ? RUN : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Digit i is always read from mr[2:0]; mc is pre-shifted to weight 4^i
  booth_r4_recoder u_recoder (
    .i_triplet (r_mr[2:0]),
    .o_op      (w_op)
  );

  always_comb begin
    w_pp = '0;
    case (w_op)
      ADD1:    w_pp = r_mc;
      ADD2:    w_pp = r_mc << 1;
      SUB1:    w_pp = -r_mc;
      SUB2:    w_pp = -(r_mc << 1);
      default: w_pp = '0;
    endcase
  end

  assign w_acc_next = r_acc + w_pp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_mc      <= '0;
      r_mr      <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_acc   <= '0;
      r_count <= '0;
      r_mc    <= {{(AW - WIDTH){w_a_sx}}, bus.a};
      r_mr    <= {{(MRW - 1 - WIDTH){w_b_sx}}, bus.b, 1'b0};
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_next;
      r_count <= r_count + 1'b1;
      r_mc    <= r_mc << 2;
      r_mr    <= r_mr >> 2;
      if (w_last) r_product <= w_acc_next[2*WIDTH-1:0];
    end
  end

  assign bus.ready   = w_ready;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_r4_seq_mult.sv
`default_nettype none
// ============================================================================
// Module  : tb_booth_r4_seq_mult
// Brief   : Scoreboard bench for the Booth multiplier at WIDTH=8 and WIDTH=3.
// Revision: 1.0 - initial release
// ============================================================================
module tb_booth_r4_seq_mult;
  import booth_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [15:0] q8[$];
  logic [15:0] q3[$];

  logic [2:0]  r_trip;
  digit_op_e   w_trip_op;
  logic [2:0]  rec_exp[8];

  booth_r4_seq_mult_if #(.WIDTH(8)) if8 ();
  booth_r4_seq_mult_if #(.WIDTH(3)) if3 ();

  booth_r4_seq_mult #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
  booth_r4_seq_mult #(.WIDTH(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
  booth_r4_recoder u_rec (.i_triplet(r_trip), .o_op(w_trip_op));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_mult(input bit s, input logic [7:0] x,
                                           input logic [7:0] y, input int w);
    longint xv, yv, p;
    xv = longint'({56'd0, x});
    yv = longint'({56'd0, y});
    if (s && x[w-1]) xv = xv - (longint'(1) << w);
    if (s && y[w-1]) yv = yv - (longint'(1) << w);
    p = xv * yv;
    return 16'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Enter at a negedge; returns at the negedge of the DONE cycle
  task automatic op8(input bit s, input logic [7:0] x, input logic [7:0] y, input bit noise);
    int cyc;
    bit busy_ok;
    if8.start = 1'b1; if8.is_signed = s; if8.a = x; if8.b = y;
    q8.push_back(ref_mult(s, x, y, 8));
    cyc = 0; busy_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if8.start = noise && (cyc == 2 || cyc == 4);
      if (if8.start) begin
        if8.a = 8'($urandom); if8.b = 8'($urandom); if8.is_signed = ~s;
      end
      if (!if8.done && !if8.busy) busy_ok = 1'b0;
    end while (!if8.done && cyc < 20);
    check("lat8", 64'(cyc), 64'd6);
    check("busy8", 64'(busy_ok), 64'd1);
    check("rdy8", 64'(if8.ready), 64'd1);
  endtask

  task automatic op3(input bit s, input logic [2:0] x, input logic [2:0] y);
    int cyc;
    if3.start = 1'b1; if3.is_signed = s; if3.a = x; if3.b = y;
    q3.push_back(ref_mult(s, {5'd0, x}, {5'd0, y}, 3));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if3.start = 1'b0;
    end while (!if3.done && cyc < 20);
    check("lat3", 64'(cyc), 64'd3);
  endtask

  always @(negedge clk) begin
    if (if8.done) begin
      if (q8.size() == 0) check("sb8_empty", 64'd1, 64'd0);
      else                check("prod8", 64'(if8.product), 64'(q8.pop_front()));
    end
    if (if3.done) begin
      if (q3.size() == 0) check("sb3_empty", 64'd1, 64'd0);
      else                check("prod3", 64'(if3.product), 64'(q3.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    n_vec = 0; n_err = 0;
    rec_exp = '{3'b000, 3'b010, 3'b010, 3'b011, 3'b110, 3'b101, 3'b101, 3'b000};
    rst = 1'b1; r_trip = 3'd0;
    if8.start = 1'b0; if8.is_signed = 1'b0; if8.a = '0; if8.b = '0;
    if3.start = 1'b0; if3.is_signed = 1'b0; if3.a = '0; if3.b = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(if8.ready), 64'd1);
    check("rst_busy", 64'(if8.busy), 64'd0);
    check("rst_done", 64'(if8.done), 64'd0);
    check("rst_prod", 64'(if8.product), 64'd0);
    check("rst_prod3", 64'(if3.product), 64'd0);
    rst = 1'b0;

    for (int t = 0; t < 8; t++) begin
      r_trip = 3'(t);
      #1;
      check("recoder", 64'(w_trip_op), 64'(rec_exp[t]));
    end
    @(negedge clk);

    op8(1'b1, 8'h80, 8'h80, 1'b0);
    check("m128sq", 64'(if8.product), 64'h4000);
    @(negedge clk);
    check("hold8", 64'(if8.product), 64'h4000);
    check("idle_rdy", 64'(if8.ready), 64'd1);
    op8(1'b0, 8'hFF, 8'hFF, 1'b0);
    check("uff", 64'(if8.product), 64'hFE01);
    @(negedge clk);
    op8(1'b1, 8'hFF, 8'hFF, 1'b0);
    check("sff", 64'(if8.product), 64'h0001);
    @(negedge clk);
    op8(1'b1, 8'd7, 8'hFD, 1'b0);
    check("s7m3", 64'(if8.product), 64'hFFEB);
    op8(1'b0, 8'd5, 8'd6, 1'b0);
    check("b2b", 64'(if8.product), 64'h001E);
    @(negedge clk);
    op8(1'b1, 8'h5A, 8'hC3, 1'b1);
    check("ignore", 64'(if8.product), 64'(ref_mult(1'b1, 8'h5A, 8'hC3, 8)));
    repeat (6) op8(1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    @(negedge clk);

    // Abort in the third RUN cycle
    if8.start = 1'b1; if8.is_signed = 1'b0; if8.a = 8'h33; if8.b = 8'h11;
    q8.push_back(ref_mult(1'b0, 8'h33, 8'h11, 8));
    @(negedge clk); if8.start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    q8.delete();
    check("abort_ready", 64'(if8.ready), 64'd1);
    check("abort_busy", 64'(if8.busy), 64'd0);
    check("abort_prod", 64'(if8.product), 64'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (if8.done) seen = 1'b1;
    end
    check("abort_nodone", 64'(seen), 64'd0);

    op3(1'b1, 3'd3, 3'b100);
    check("legacy3", 64'(if3.product), 64'h34);
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 8; y++)
          op3(1'(s), 3'(x), 3'(y));
    repeat (2) @(negedge clk);
    check("sb8_left", 64'(q8.size()), 64'd0);
    check("sb3_left", 64'(q3.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_r4_seq_mult.md
Name: booth_r4_seq_mult

Overview:
Parametrised sequential radix-4 Booth multiplier with its own controller and datapath. It is the successor of the fixed 3-bit, two-digit Booth control unit. It supports any operand width, signed or unsigned operands selected per operation, a start/ready/done handshake and back-to-back issue. It sits beside the ALU as a standalone multi-cycle multiply unit.

Parameters:
WIDTH, 8, operand width in bits (legal: >= 2; odd widths allowed)
ITER, WIDTH/2+1, Booth digit count and RUN cycles (derived localparam, not overridable)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; accepted only when ready=1
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
a  input  WIDTH  multiplicand; sampled with start
b  input  WIDTH  multiplier; sampled with start
ready  output  1  high in IDLE and DONE
busy  output  1  high in RUN
done  output  1  one-cycle pulse in DONE
product  output  2*WIDTH  result; valid from DONE and held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, product=0, accumulator=0, digit counter=0.
- Reset mid-RUN aborts the operation with no done pulse. The next cycle is IDLE with product=0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 moves to RUN.
  - RUN: stays in RUN while count < ITER-1, then moves to DONE.
  - DONE: start=1 moves to RUN (back-to-back issue); otherwise moves to IDLE.
- start while busy=1 is ignored and does not disturb the operation. start is level-sampled; a held start reissues from DONE.
- On accept:
  - Multiplicand M = a extended to WIDTH+2 bits (sign-extended if is_signed, else zero-extended).
  - Multiplier register = {b extended to 2*ITER bits with the same rule, 1'b0 appended at LSB}.
  - acc=0, count=0.
- Each RUN cycle (digit i = count):
  - Triplet t = {mr[2i+2], mr[2i+1], mr[2i]} of the appended register.
  - Recode: 000/111 -> 0, 001/010 -> +M, 011 -> +2M, 100 -> -2M, 101/110 -> -M.
  - acc += sign-extended PP << 2i. acc is 2*WIDTH+4 bits; arithmetic is modulo 2^(2*WIDTH+4).
  - count increments.
  - Implementation may instead right-shift acc/mr by 2 per cycle; the result is the same.
- product = acc[2*WIDTH-1:0], registered on the RUN->DONE edge. It is exact for both modes because the extra digit covers the unsigned MSB.
- Latency: start sampled at the end of cycle 0 -> busy high in cycles 1..ITER -> done and valid product in cycle ITER+1. Throughput is one result per ITER+1 cycles.
- In DONE: ready=1 and done=1 together. is_signed, a and b are don't-care outside the accept cycle.

Decomposition:
- Package booth_pkg:
  - State enum (IDLE, RUN, DONE).
  - Digit-op encoding, matching the legacy ALUop values: ZERO=3'b000, ADD1=3'b010, ADD2=3'b011, SUB1=3'b101, SUB2=3'b110.
  - Function computing ITER from WIDTH.
- Sub-module booth_r4_recoder: combinational; 3-bit triplet in, digit op out. Instantiated once; it is also the unit-test target for all 8 triplets.

Test Plan:
- WIDTH=8, signed, a=-128 (0x80), b=-128 -> done in cycle 6, product=16'h4000; busy high in cycles 1..5.
- WIDTH=8, unsigned, a=0xFF, b=0xFF -> product=16'hFE01. Same operands signed -> 16'h0001.
- WIDTH=8, signed, a=7, b=-3 -> product=16'hFFEB. Then start held high in the DONE cycle with a=5, b=6 unsigned -> second done exactly 6 cycles later, product=16'h001E.
- WIDTH=8: start pulses with different operands in RUN cycles 2 and 4 are ignored; product equals the first operation's result.
- WIDTH=8: rst=1 in RUN cycle 3 -> next cycle IDLE, ready=1, product=0, and no done pulse in the following 10 cycles.
- WIDTH=3 (legacy equivalence), signed, a=3, b=-4 -> ITER=2, done in cycle 3, product=6'h34 (-12). Plus an exhaustive sweep of all 64 signed and 64 unsigned pairs against a reference model.
